// File: rtl/spwm_pkg.sv
// spwm_pkg: shared types and constants for the three-phase SPWM reference
// scheduler.
//   state_t      : sequencer state encoding
//   PHASE_OFS_B/C: ROM index offsets for phases B and C (120/240 degrees of 256)
//   SCALE_SHIFT  : right shift applied to amplitude x sine product
//   ROM_AW       : sine ROM address width
package spwm_pkg;

  localparam int unsigned ROM_AW      = 8;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned AMP_W       = 16;
  localparam int unsigned PROD_W      = 33;
  localparam int unsigned SCALE_SHIFT = 12;
  localparam int unsigned CNT_W       = 11;

  localparam logic [ROM_AW-1:0] PHASE_OFS_B = ROM_AW'(85);
  localparam logic [ROM_AW-1:0] PHASE_OFS_C = ROM_AW'(171);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_A = 3'd1,
    ADDR_B = 3'd2,
    ADDR_C = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/spwm_scale.sv
// spwm_scale: combinational amplitude scaler shared by all three phases.
//   amp      : unsigned amplitude (DC-bus scale)
//   rom_word : signed sine sample
//   scaled_c : (amp * rom_word) >>> SCALE_SHIFT reduced to DATA_W bits
// Build option: define SPWM_SAT_EN to saturate the reduced result to the
// signed 16-bit range; otherwise the low 16 bits are taken.
module spwm_scale
  import spwm_pkg::*;
(
  input  logic        [AMP_W-1:0]  amp,
  input  logic signed [DATA_W-1:0] rom_word,
  output logic signed [DATA_W-1:0] scaled_c
);

  logic signed [PROD_W-1:0] amp_s;
  logic signed [PROD_W-1:0] word_s;
  logic signed [PROD_W-1:0] prod;

  // Amplitude is unsigned: prepend a zero before treating it as signed.
  always_comb begin
    amp_s  = PROD_W'($signed({1'b0, amp}));
    word_s = PROD_W'(rom_word);
    prod   = amp_s * word_s;
  end

`ifdef SPWM_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32768);

  logic signed [PROD_W-1:0] shifted;

  // Clamp the shifted product into the signed output range.
  always_comb begin
    shifted = prod >>> SCALE_SHIFT;
    if (shifted > SAT_MAX) begin
      scaled_c = 16'sh7FFF;
    end else if (shifted < SAT_MIN) begin
      scaled_c = 16'sh8000;
    end else begin
      scaled_c = DATA_W'(shifted);
    end
  end
`else
  // Plain truncation of the shifted product.
  always_comb begin
    scaled_c = DATA_W'(prod >>> SCALE_SHIFT);
  end
`endif

endmodule

// File: rtl/spwm_phase_sched.sv
// spwm_phase_sched: once per sample step, reads the shared sine ROM at the
// three phase positions, scales by the sampled amplitude and publishes the
// three phase references together.
//   clk_20M     : clock, rising edge
//   reset       : asynchronous active-high reset
//   enable      : run request (a started step always completes)
//   amp_udc     : unsigned amplitude, sampled at step start
//   rom_addr    : sine ROM address (registered ROM, one-cycle latency)
//   rom_data    : signed ROM word
//   vol_a/b/c   : signed phase references
//   vol_valid   : one-cycle pulse when vol_a/b/c update
//   cycle_start : one-cycle pulse when the sine base index wraps 255->0
// Build option: SPWM_SAT_EN selects saturation in spwm_scale.
module spwm_phase_sched
  import spwm_pkg::*;
#(
  parameter int unsigned PARA_STEP = 1559
) (
  input  logic                     clk_20M,
  input  logic                     reset,
  input  logic                     enable,
  input  logic        [AMP_W-1:0]  amp_udc,
  output logic        [ROM_AW-1:0] rom_addr,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic signed [DATA_W-1:0] vol_a,
  output logic signed [DATA_W-1:0] vol_b,
  output logic signed [DATA_W-1:0] vol_c,
  output logic                     vol_valid,
  output logic                     cycle_start
);

  state_t                    state, state_nxt;
  logic        [CNT_W-1:0]   step_cnt;
  logic                      tick_c;
  logic        [ROM_AW-1:0]  base, base_nxt;
  logic        [ROM_AW-1:0]  rom_addr_nxt;
  logic        [AMP_W-1:0]   amp_q, amp_nxt;
  logic signed [DATA_W-1:0]  hold_a, hold_a_nxt;
  logic signed [DATA_W-1:0]  hold_b, hold_b_nxt;
  logic signed [DATA_W-1:0]  vol_a_nxt, vol_b_nxt, vol_c_nxt;
  logic                      vol_valid_nxt;
  logic                      cycle_start_nxt;
  logic signed [DATA_W-1:0]  scaled_c;

  // Sample-step timer: tick on the cycle the count reaches PARA_STEP.
  assign tick_c = enable && (step_cnt == CNT_W'(PARA_STEP));

  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
    end else if (!enable || tick_c) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  // Single scaler, fed directly from the ROM output each cycle.
  spwm_scale u_scale (
    .amp      (amp_q),
    .rom_word (rom_data),
    .scaled_c (scaled_c)
  );

  // Sequencer next-state and datapath next values.
  // rom_data in ADDR_B/ADDR_C/WAIT answers the address issued one cycle
  // earlier, so phase A/B/C results appear in those three states.
  always_comb begin
    state_nxt       = state;
    base_nxt        = base;
    rom_addr_nxt    = rom_addr;
    amp_nxt         = amp_q;
    hold_a_nxt      = hold_a;
    hold_b_nxt      = hold_b;
    vol_a_nxt       = vol_a;
    vol_b_nxt       = vol_b;
    vol_c_nxt       = vol_c;
    vol_valid_nxt   = 1'b0;
    cycle_start_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (tick_c) begin
          state_nxt    = ADDR_A;
          rom_addr_nxt = base;
          amp_nxt      = amp_udc;
        end
      end
      ADDR_A: begin
        state_nxt    = ADDR_B;
        rom_addr_nxt = base + PHASE_OFS_B;
      end
      ADDR_B: begin
        state_nxt    = ADDR_C;
        rom_addr_nxt = base + PHASE_OFS_C;
        hold_a_nxt   = scaled_c;
      end
      ADDR_C: begin
        state_nxt  = WAIT;
        hold_b_nxt = scaled_c;
      end
      WAIT: begin
        state_nxt       = DONE;
        vol_a_nxt       = hold_a;
        vol_b_nxt       = hold_b;
        vol_c_nxt       = scaled_c;
        vol_valid_nxt   = 1'b1;
        cycle_start_nxt = (base == '1);
      end
      DONE: begin
        state_nxt = IDLE;
        base_nxt  = base + ROM_AW'(1);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      rom_addr    <= '0;
      amp_q       <= '0;
      hold_a      <= '0;
      hold_b      <= '0;
      vol_a       <= '0;
      vol_b       <= '0;
      vol_c       <= '0;
      vol_valid   <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      base        <= base_nxt;
      rom_addr    <= rom_addr_nxt;
      amp_q       <= amp_nxt;
      hold_a      <= hold_a_nxt;
      hold_b      <= hold_b_nxt;
      vol_a       <= vol_a_nxt;
      vol_b       <= vol_b_nxt;
      vol_c       <= vol_c_nxt;
      vol_valid   <= vol_valid_nxt;
      cycle_start <= cycle_start_nxt;
    end
  end

endmodule

// File: doc/spwm_phase_sched.md
SPWM_PHASE_SCHED -- requirements
Module: spwm_phase_sched

Interface
REQ-001 SHALL have parameter PARA_STEP, default 1559, clocks per sample step minus one (1560 x 50 ns = 78 us); legal range 8..2047.
REQ-002 SHALL have port clk_20M  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  run request.
REQ-005 SHALL have port amp_udc  input  16  unsigned amplitude (DC-bus scale).
REQ-006 SHALL have port rom_addr  output  8  address to the shared 256-point sine ROM.
REQ-007 SHALL have port rom_data  input  16  signed ROM word; registered ROM, one-cycle read latency.
REQ-008 SHALL have ports vol_a, vol_b, vol_c  output  16 each  signed phase references.
REQ-009 SHALL have port vol_valid  output  1  one-cycle pulse when vol_a/b/c update.
REQ-010 SHALL have port cycle_start  output  1  one-cycle pulse when the sine base index wraps 255->0.

Function
REQ-011 Step counter SHALL count 0..PARA_STEP while enable=1 and issue a tick on the cycle it equals PARA_STEP, then return to 0; counter held at 0 while enable=0.
REQ-012 FSM states SHALL be IDLE, ADDR_A, ADDR_B, ADDR_C, WAIT, DONE.
REQ-013 IDLE->ADDR_A on tick; ADDR_A->ADDR_B->ADDR_C->WAIT->DONE unconditionally, one cycle each; DONE->IDLE.
REQ-014 rom_addr SHALL be base in ADDR_A, (base+85) mod 256 in ADDR_B, (base+171) mod 256 in ADDR_C; rom_addr holds its last value in other states.
REQ-015 amp_udc SHALL be sampled once on entry to ADDR_A and used for all three phases of that step.
REQ-016 rom_data SHALL be captured for phase A at end of ADDR_B, B at end of ADDR_C, C at end of WAIT.
REQ-017 Each phase value SHALL be (amp_udc x rom_data) as a signed 33-bit product, arithmetic-shifted right by 12, reduced to 16 bits per REQ-026.
REQ-018 vol_a/b/c SHALL update together at end of WAIT; vol_valid SHALL be high during DONE only (4 cycles after ADDR_A entry).
REQ-019 In DONE base SHALL increment mod 256; cycle_start SHALL pulse in DONE when base goes 255->0.
REQ-020 enable deasserted mid-sequence: sequence SHALL complete through DONE, then remain in IDLE; outputs hold.
REQ-021 Ticks occurring outside IDLE SHALL be impossible by REQ-001 range; no queueing required.

Reset
REQ-022 While reset=1: state IDLE, step counter 0, base 0, rom_addr 0, vol_a/b/c 0, vol_valid 0, cycle_start 0.
REQ-023 Reset asserted mid-sequence SHALL abort immediately; no vol_valid for the aborted step.
REQ-024 After reset release, first tick SHALL occur PARA_STEP+1 cycles after enable is first sampled high.

Configuration
REQ-025 Macro SPWM_SAT_EN selects output reduction.
REQ-026 With SPWM_SAT_EN defined: shifted result SHALL saturate to 0x7FFF..0x8000; without it: low 16 bits taken (truncation, no saturation logic).

Structure
REQ-027 Package spwm_pkg SHALL hold the FSM state enum, phase offsets 85 and 171, shift constant 12, and ROM address width 8.
REQ-028 Sub-module spwm_scale (multiply, shift, saturate/truncate) SHALL be instantiated once and time-shared across phases; the ROM remains outside this block.

Verification (PARA_STEP=15, registered ROM model)
REQ-029 ROM returns 0x0800 at every address, amp_udc=4096, enable=1 -> vol_a=vol_b=vol_c=0x0800, vol_valid every 16 cycles.
REQ-030 base=0 -> rom_addr 0,85,171 in consecutive cycles; base=200 -> 200,29,115.
REQ-031 amp_udc=0xFFFF, rom_data=0x7FFF -> 0x7FFF with SPWM_SAT_EN, 0xFFE7 without; rom_data=0x8000 -> 0x8000 with SPWM_SAT_EN.
REQ-032 256 consecutive steps from reset -> exactly one cycle_start, in the DONE cycle of step 256, base returns to 0.
REQ-033 enable dropped in ADDR_B -> vol_valid still pulses once, then no further rom_addr activity; reset in ADDR_C -> all outputs 0 next cycle, no vol_valid.
